mem_access_ctrl: RTL and testbench

- Sequences the byte-addressable single-port data RAM (32-bit word write, asynchronous 32-bit read, big-endian byte order).
- Shares it between the CPU MEM stage and the debug loader through a round-robin arbiter.
- Implements sub-word stores (SB/SH) as read-modify-write, and sub-word loads (LB/LBU/LH/LHU) with extension.
- Stalls the pipeline while the CPU's access is in flight.

---
 rtl/mem_access_ctrl.sv | 96 +++++++++
 tb/tb_mem_access_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: round-robin CPU/debug access to a big-endian byte RAM (RMW sub-word stores, extended loads, misalign detect); ports: i_cpu_*/o_cpu_* MEM stage, i_dbg_*/o_dbg_* loader, o_mem_*/i_mem_rdata RAM, o_busy
module mem_access_ctrl #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_cpu_req,
  input  logic               i_cpu_we,
  input  logic [1:0]         i_cpu_size,
  input  logic               i_cpu_unsigned,
  input  logic [NB_ADDR-1:0] i_cpu_addr,
  input  logic [NB_DATA-1:0] i_cpu_wdata,
  output logic [NB_DATA-1:0] o_cpu_rdata,
  output logic               o_cpu_done,
  output logic               o_cpu_stall,
  output logic               o_misalign_err,
  input  logic               i_dbg_req,
  input  logic               i_dbg_we,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  input  logic [NB_DATA-1:0] i_dbg_wdata,
  output logic [NB_DATA-1:0] o_dbg_rdata,
  output logic               o_dbg_ack,
  output logic               o_mem_we,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic [NB_DATA-1:0] o_mem_wdata,
  input  logic [NB_DATA-1:0] i_mem_rdata,
  output logic               o_busy
);
  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;
  state_t r_state, w_next;
  logic r_last_dbg, r_gnt_dbg, r_uns, r_mis;
  logic [1:0] r_size;
  logic [NB_ADDR-1:0] r_addr;
  logic [NB_DATA-1:0] r_wdata, r_rmw;
  logic w_pick_dbg, w_accept, w_cpu_mis;
  logic [4:0] w_sh;
  logic [NB_DATA-1:0] w_lane, w_mask, w_merge, w_ext;
  assign w_pick_dbg = i_dbg_req & (~i_cpu_req | ~r_last_dbg);
  assign w_accept = i_cpu_req | i_dbg_req;
  assign w_cpu_mis = (i_cpu_size == 2'b00) ? 1'b0 : (i_cpu_size == 2'b01) ? i_cpu_addr[0] : |i_cpu_addr[1:0];
  assign w_sh = (r_size == 2'b00) ? {~r_addr[1:0], 3'b000} : {~r_addr[1], 4'b0000};
  assign w_lane = i_mem_rdata >> w_sh;
  assign w_mask = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << w_sh;
  assign w_merge = (r_rmw & ~w_mask) | ((r_wdata << w_sh) & w_mask);
  assign w_ext = (r_size == 2'b00) ? {{24{w_lane[7] & ~r_uns}}, w_lane[7:0]} :
                 (r_size == 2'b01) ? {{16{w_lane[15] & ~r_uns}}, w_lane[15:0]} : i_mem_rdata;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = !w_accept ? IDLE : w_pick_dbg ? (i_dbg_we ? STORE : LOAD) :
                     w_cpu_mis ? RESP : !i_cpu_we ? LOAD : i_cpu_size[1] ? STORE : RMW_RD;
      LOAD, STORE, RMW_WR: w_next = RESP;
      RMW_RD: w_next = RMW_WR;
      default: w_next = IDLE;
    endcase
  end
  assign o_busy = (r_state != IDLE);
  assign o_mem_we = ((r_state == STORE) | (r_state == RMW_WR)) & ~i_rst;
  assign o_mem_addr = o_busy ? {r_addr[NB_ADDR-1:2], 2'b00} : '0;
  assign o_mem_wdata = (r_state == STORE) ? r_wdata : (r_state == RMW_WR) ? w_merge : '0;
  assign o_cpu_done = (r_state == RESP) & ~r_gnt_dbg;
  assign o_dbg_ack = (r_state == RESP) & r_gnt_dbg;
  assign o_misalign_err = (r_state == RESP) & r_mis;
  assign o_cpu_stall = i_cpu_req & ~o_cpu_done;
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_last_dbg <= 1'b1;
      r_gnt_dbg <= 1'b0;
      r_uns <= 1'b0;
      r_mis <= 1'b0;
      r_size <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      r_rmw <= '0;
      o_cpu_rdata <= '0;
      o_dbg_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_accept) begin
        r_last_dbg <= w_pick_dbg;
        r_gnt_dbg <= w_pick_dbg;
        r_size <= w_pick_dbg ? 2'b10 : i_cpu_size;
        r_uns <= i_cpu_unsigned;
        r_addr <= w_pick_dbg ? (i_dbg_addr & ~NB_ADDR'(3)) : i_cpu_addr;
        r_wdata <= w_pick_dbg ? i_dbg_wdata : i_cpu_wdata;
        r_mis <= ~w_pick_dbg & w_cpu_mis;
        if (~w_pick_dbg & w_cpu_mis) o_cpu_rdata <= '0;
      end
      if (r_state == RMW_RD) r_rmw <= i_mem_rdata;
      if (r_state == LOAD && r_gnt_dbg) o_dbg_rdata <= i_mem_rdata;
      if (r_state == LOAD && !r_gnt_dbg) o_cpu_rdata <= w_ext;
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized checks of mem_access_ctrl against a byte-array memory model
module tb_mem_access_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0, cpu_uns = 1'b0;
  logic [1:0] cpu_size = 2'b00;
  logic [7:0] cpu_addr = 8'h00;
  logic [31:0] cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic cpu_done, cpu_stall, mis_err;
  logic dbg_req = 1'b0, dbg_we = 1'b0;
  logic [7:0] dbg_addr = 8'h00;
  logic [31:0] dbg_wdata = 32'h0;
  logic [31:0] dbg_rdata;
  logic dbg_ack;
  logic mem_we, busy;
  logic [7:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] ram [64] = '{default: 32'h0};
  logic [7:0] rb [256];
  logic [7:0] last_wa = 8'h00;
  logic [108:0] all_out;
  int we_cnt = 0;
  int n_tests = 0, n_fail = 0;
  mem_access_ctrl #(.NB_DATA(32), .NB_ADDR(8)) dut (
    .clk(clk), .i_rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_size(cpu_size), .i_cpu_unsigned(cpu_uns),
    .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(cpu_rdata), .o_cpu_done(cpu_done),
    .o_cpu_stall(cpu_stall), .o_misalign_err(mis_err),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .o_dbg_rdata(dbg_rdata), .o_dbg_ack(dbg_ack),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
    .o_busy(busy)
  );
  always #5 clk = ~clk;
  assign mem_rdata = ram[mem_addr[7:2]];
  assign all_out = {mem_we, mem_addr, mem_wdata, cpu_rdata, dbg_rdata, cpu_done, dbg_ack, mis_err, busy};
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr[7:2]] <= mem_wdata;
      we_cnt <= we_cnt + 1;
      last_wa <= mem_addr;
    end
  end
  function automatic logic mis_f(input logic [1:0] sz, input logic [7:0] a);
    return (sz == 2'b00) ? 1'b0 : (sz == 2'b01) ? a[0] : (a[1:0] != 2'b00);
  endfunction
  function automatic logic [31:0] word_f(input logic [7:0] a);
    int b = {24'h0, a[7:2], 2'b00};
    return {rb[b], rb[b+1], rb[b+2], rb[b+3]};
  endfunction
  function automatic logic [31:0] load_f(input logic [1:0] sz, input logic uns, input logic [7:0] a);
    logic [15:0] h = {rb[a], rb[8'(a + 8'd1)]};
    if (mis_f(sz, a)) return 32'h0;
    if (sz == 2'b00) return uns ? {24'h0, rb[a]} : {{24{rb[a][7]}}, rb[a]};
    if (sz == 2'b01) return uns ? {16'h0, h} : {{16{h[15]}}, h};
    return word_f(a);
  endfunction
  function automatic void store_f(input logic [1:0] sz, input logic [7:0] a, input logic [31:0] d);
    if (mis_f(sz, a)) return;
    if (sz == 2'b00) rb[a] = d[7:0];
    else if (sz == 2'b01) begin
      rb[a] = d[15:8];
      rb[8'(a + 8'd1)] = d[7:0];
    end else for (int i = 0; i < 4; i++) rb[int'(a) + i] = d[31-8*i -: 8];
  endfunction
  task automatic cpu_op(input logic we, input logic [1:0] sz, input logic uns, input logic [7:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic mis, output int lat, output int nw, output logic side);
    int w0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_size = sz; cpu_uns = uns; cpu_addr = a; cpu_wdata = wd;
    w0 = we_cnt; lat = 0; side = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        cpu_we = 1'($urandom); cpu_size = 2'($urandom); cpu_uns = 1'($urandom);
        cpu_addr = 8'($urandom); cpu_wdata = $urandom;
      end
      if (dbg_ack || (mis_err && !cpu_done) || cpu_stall !== !cpu_done) side = 1'b1;
    end while (!cpu_done && lat < 12);
    rd = cpu_rdata; mis = mis_err; cpu_req = 1'b0;
    nw = we_cnt - w0;
  endtask
  task automatic dbg_op(input logic we, input logic [7:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat, output int nw, output logic side);
    int w0;
    @(negedge clk);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
    w0 = we_cnt; lat = 0; side = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        dbg_we = 1'($urandom); dbg_addr = 8'($urandom); dbg_wdata = $urandom;
      end
      if (cpu_done || mis_err) side = 1'b1;
    end while (!dbg_ack && lat < 12);
    rd = dbg_rdata; dbg_req = 1'b0;
    nw = we_cnt - w0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (all_out !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    n_tests++;
    if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
    rst = 1'b0;
  endtask
  task automatic test_word;
    logic [31:0] rd; logic mis, side; int lat, nw;
    cpu_op(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, rd, mis, lat, nw, side);
    store_f(2'b10, 8'h10, 32'hDEADBEEF);
    n_tests++;
    if (lat != 2 || nw != 1 || last_wa !== 8'h10 || mis || side) begin
      n_fail++; $display("FAIL sw: lat=%0d nw=%0d addr=%h mis=%b side=%b want 2 1 10 0 0", lat, nw, last_wa, mis, side);
    end
    cpu_op(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, rd, mis, lat, nw, side);
    n_tests++;
    if (rd !== 32'hDEADBEEF || lat != 2 || nw != 0 || mis || side) begin
      n_fail++; $display("FAIL lw: rd=%h lat=%0d nw=%0d want deadbeef 2 0", rd, lat, nw);
    end
  endtask
  task automatic test_subword;
    logic [31:0] rd; logic mis, side; int lat, nw;
    logic [1:0] sz [3] = '{2'b00, 2'b00, 2'b01};
    logic un [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] ex [3] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFFAA44};
    dbg_op(1'b1, 8'h20, 32'h11223344, rd, lat, nw, side);
    store_f(2'b10, 8'h20, 32'h11223344);
    cpu_op(1'b1, 2'b00, 1'b0, 8'h22, 32'h123456AA, rd, mis, lat, nw, side);
    store_f(2'b00, 8'h22, 32'h123456AA);
    n_tests++;
    if (lat != 3 || nw != 1 || ram[8] !== 32'h1122AA44 || mis || side) begin
      n_fail++; $display("FAIL sb_rmw: lat=%0d nw=%0d ram=%h want 3 1 1122aa44", lat, nw, ram[8]);
    end
    for (int i = 0; i < 3; i++) begin
      cpu_op(1'b0, sz[i], un[i], 8'h22, $urandom, rd, mis, lat, nw, side);
      n_tests++;
      if (rd !== ex[i] || rd !== load_f(sz[i], un[i], 8'h22) || lat != 2 || nw != 0 || side) begin
        n_fail++; $display("FAIL subload%0d: rd=%h lat=%0d want %h 2", i, rd, lat, ex[i]);
      end
    end
  endtask
  task automatic test_misalign;
    logic [31:0] rd, ex; logic mis, side, em; int lat, nw, el;
    logic w [3] = '{1'b0, 1'b0, 1'b1};
    logic [1:0] sz [3] = '{2'b10, 2'b10, 2'b01};
    logic [7:0] ad [3] = '{8'h21, 8'h20, 8'h23};
    for (int i = 0; i < 3; i++) begin
      ex = load_f(sz[i], 1'b0, ad[i]);
      em = mis_f(sz[i], ad[i]);
      el = em ? 1 : 2;
      cpu_op(w[i], sz[i], 1'b0, ad[i], 32'hCAFEF00D, rd, mis, lat, nw, side);
      n_tests++;
      if (rd !== ex || mis !== em || lat != el || nw != 0 || ram[8] !== word_f(8'h20) || side) begin
        n_fail++; $display("FAIL misalign%0d: rd=%h mis=%b lat=%0d nw=%0d ram=%h want %h %b %0d 0 %h", i, rd, mis, lat, nw, ram[8], ex, em, el, word_f(8'h20));
      end
    end
  endtask
  task automatic test_arb;
    logic [2:0] order = 3'b000; logic bad = 1'b0; int k = 0, cyc = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_uns = 1'b0; cpu_addr = 8'h10;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h20;
    while (k < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cpu_stall !== !cpu_done || (cpu_done && dbg_ack)) bad = 1'b1;
      if (cpu_done) begin
        n_tests++;
        if (cpu_rdata !== load_f(2'b10, 1'b0, 8'h10)) begin n_fail++; $display("FAIL arb_cpu_rd: got %h want %h", cpu_rdata, load_f(2'b10, 1'b0, 8'h10)); end
      end
      if (dbg_ack) begin
        n_tests++;
        if (dbg_rdata !== word_f(8'h20)) begin n_fail++; $display("FAIL arb_dbg_rd: got %h want %h", dbg_rdata, word_f(8'h20)); end
      end
      if (cpu_done || dbg_ack) begin
        order[k] = dbg_ack;
        k++;
      end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    n_tests++;
    if (k != 3 || order !== 3'b010 || bad) begin
      n_fail++; $display("FAIL arb_order: done=%0d order=%b bad=%b want 3 010 0", k, order, bad);
    end
  endtask
  task automatic test_dbg;
    logic [31:0] rd; logic side; int lat, nw;
    dbg_op(1'b1, 8'h33, 32'h01020304, rd, lat, nw, side);
    store_f(2'b10, 8'h30, 32'h01020304);
    n_tests++;
    if (lat != 2 || nw != 1 || last_wa !== 8'h30 || ram[12] !== 32'h01020304 || side) begin
      n_fail++; $display("FAIL dbg_wr: lat=%0d nw=%0d addr=%h ram=%h side=%b want 2 1 30 01020304 0", lat, nw, last_wa, ram[12], side);
    end
    dbg_op(1'b0, 8'h30, 32'h0, rd, lat, nw, side);
    n_tests++;
    if (rd !== 32'h01020304 || lat != 2 || nw != 0 || side) begin
      n_fail++; $display("FAIL dbg_rd: rd=%h lat=%0d want 01020304 2", rd, lat);
    end
  endtask
  task automatic test_reset_rmw;
    logic [31:0] rd; logic mis, side; int lat, nw, w0;
    dbg_op(1'b1, 8'h40, 32'h55667788, rd, lat, nw, side);
    store_f(2'b10, 8'h40, 32'h55667788);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b00; cpu_uns = 1'b0; cpu_addr = 8'h41; cpu_wdata = 32'h000000CC;
    repeat (2) @(negedge clk);
    n_tests++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h40 || mem_wdata !== 32'h55CC7788) begin
      n_fail++; $display("FAIL rmw_wr_phase: we=%b addr=%h wdata=%h want 1 40 55cc7788", mem_we, mem_addr, mem_wdata);
    end
    w0 = we_cnt;
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if (all_out !== '0) begin n_fail++; $display("FAIL rmw_reset_outputs: got %h want 0", all_out); end
    n_tests++;
    if (we_cnt != w0 || ram[16] !== 32'h55667788) begin
      n_fail++; $display("FAIL rmw_reset_ram: writes=%0d ram=%h want 0 55667788", we_cnt - w0, ram[16]);
    end
    rst = 1'b0;
    cpu_op(1'b0, 2'b10, 1'b0, 8'h40, 32'h0, rd, mis, lat, nw, side);
    n_tests++;
    if (rd !== 32'h55667788 || lat != 2 || mis || side) begin
      n_fail++; $display("FAIL rmw_after_reset: rd=%h lat=%0d want 55667788 2", rd, lat);
    end
  endtask
  task automatic test_random;
    logic [31:0] rd, ex, held, d; logic mis, side, we, uns, em; logic [1:0] sz; logic [7:0] a; int lat, nw, el, bad;
    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom); a = 8'($urandom); d = $urandom;
      if ($urandom_range(3) == 0) begin
        held = cpu_rdata;
        ex = word_f(a);
        dbg_op(we, a, d, rd, lat, nw, side);
        if (we) store_f(2'b10, {a[7:2], 2'b00}, d);
        n_tests++;
        if ((!we && rd !== ex) || lat != 2 || nw != (we ? 1 : 0) || side || cpu_rdata !== held) begin
          n_fail++; $display("FAIL rand_dbg%0d: we=%b a=%h rd=%h lat=%0d nw=%0d cpu_rd=%h want rd=%h lat=2 cpu_rd=%h", i, we, a, rd, lat, nw, cpu_rdata, ex, held);
        end
      end else begin
        sz = 2'($urandom); uns = 1'($urandom);
        if ($urandom_range(1) == 1) a[1:0] = 2'b00;
        ex = load_f(sz, uns, a);
        em = mis_f(sz, a);
        el = em ? 1 : (we && sz < 2'b10) ? 3 : 2;
        cpu_op(we, sz, uns, a, d, rd, mis, lat, nw, side);
        if (we) store_f(sz, a, d);
        n_tests++;
        if (((!we || em) && rd !== ex) || mis !== em || lat != el || nw != ((we && !em) ? 1 : 0) || side) begin
          n_fail++; $display("FAIL rand_cpu%0d: we=%b sz=%0d a=%h rd=%h mis=%b lat=%0d nw=%0d want rd=%h mis=%b lat=%0d", i, we, sz, a, rd, mis, lat, nw, ex, em, el);
        end
      end
    end
    bad = 0;
    for (int j = 0; j < 64; j++) if (ram[j] !== word_f(8'(j * 4))) bad++;
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL ram_image: got %0d differing words want 0", bad); end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) rb[i] = 8'h00;
    test_reset;
    test_word;
    test_subword;
    test_misalign;
    test_arb;
    test_dbg;
    test_reset_rmw;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
